// File: rtl/assoc_cache_controller.sv
// assoc_cache_controller: N-way set-associative, write-back/write-allocate cache
// controller. Holds the tag, valid and dirty bits and the round-robin victim
// pointers. It decides hit or miss and sequences the victim write-back and the
// block refill with main memory, one word per mem_ready. It also drives the
// address and write controls of the external data array, which holds the data.
// Ports: clk/reset (sync, active-high); addr_in, mem_read, mem_write from the CPU;
// stall and hit to the CPU; cache_way/index/offset/we/fill to the data array;
// mem_re/mem_we/mem_addr and mem_ready with main memory.
module assoc_cache_controller #(
  parameter int DATA_MEM_WORDS = 1024,
  parameter int CACHE_WORDS    = 128,
  parameter int BLOCK_WORDS    = 4,
  parameter int WAYS           = 2,
  localparam int SETS = CACHE_WORDS / (BLOCK_WORDS * WAYS),
  localparam int OFF  = $clog2(BLOCK_WORDS),
  localparam int IDX  = $clog2(SETS),
  localparam int AW   = $clog2(DATA_MEM_WORDS),
  localparam int TAG  = AW - OFF - IDX,
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr_in,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_ready,
  output logic            stall,
  output logic            hit,
  output logic [WB-1:0]   cache_way,
  output logic [IDX-1:0]  cache_index,
  output logic [OFF-1:0]  cache_offset,
  output logic            cache_we,
  output logic            cache_fill,
  output logic            mem_re,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t          state;
  logic [OFF-1:0]  beat;

  // Per-set, per-way line state; per-set replacement pointer.
  logic [TAG-1:0]  tag_mem   [SETS][WAYS];
  logic [WAYS-1:0] valid_mem [SETS];
  logic [WAYS-1:0] dirty_mem [SETS];
  logic [WB-1:0]   rr_ptr    [SETS];

  // Miss context captured on leaving IDLE; only these are used during transfers.
  logic [TAG-1:0]  lat_tag;
  logic [TAG-1:0]  lat_vtag;
  logic [IDX-1:0]  lat_idx;
  logic [WB-1:0]   lat_way;
  logic            lat_by_ptr;

  logic [OFF-1:0]  a_off;
  logic [IDX-1:0]  a_idx;
  logic [TAG-1:0]  a_tag;
  logic            unused_addr;

  assign a_off       = addr_in[OFF-1:0];
  assign a_idx       = addr_in[OFF +: IDX];
  assign a_tag       = addr_in[OFF+IDX +: TAG];
  assign unused_addr = ^addr_in[31:AW];

  logic            req;
  logic            lk_hit;
  logic [WB-1:0]   lk_way;
  logic            vic_found;
  logic [WB-1:0]   vic_way;
  logic            vic_dirty;
  logic            last_beat;

  assign req       = mem_read | mem_write;
  assign last_beat = (beat == OFF'(BLOCK_WORDS - 1));

  // Tag lookup and victim choice on the live CPU address.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    vic_found = 1'b0;
    vic_way   = rr_ptr[a_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_mem[a_idx][w] && (tag_mem[a_idx][w] == a_tag)) begin
        lk_hit = 1'b1;
        lk_way = WB'(w);
      end
      // Lowest-index invalid way wins over the round-robin pointer.
      if (!vic_found && !valid_mem[a_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WB'(w);
      end
    end
    if (WAYS == 1) begin
      vic_way = '0;
    end
    vic_dirty = valid_mem[a_idx][vic_way] & dirty_mem[a_idx][vic_way];
  end

  // Outputs are combinational from state, beat counter and lookup.
  always_comb begin
    stall        = 1'b0;
    hit          = 1'b0;
    cache_way    = lk_way;
    cache_index  = a_idx;
    cache_offset = a_off;
    cache_we     = 1'b0;
    cache_fill   = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    case (state)
      IDLE: begin
        stall    = req & ~lk_hit;
        hit      = req & lk_hit;
        cache_we = mem_write & lk_hit;
      end
      WRITEBACK: begin
        stall        = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = {lat_vtag, lat_idx, beat};
        cache_way    = lat_way;
        cache_index  = lat_idx;
        cache_offset = beat;
      end
      REFILL: begin
        stall        = 1'b1;
        mem_re       = 1'b1;
        mem_addr     = {lat_tag, lat_idx, beat};
        cache_way    = lat_way;
        cache_index  = lat_idx;
        cache_offset = beat;
        cache_we     = mem_ready;
        cache_fill   = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      lat_tag    <= '0;
      lat_vtag   <= '0;
      lat_idx    <= '0;
      lat_way    <= '0;
      lat_by_ptr <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        rr_ptr[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (lk_hit) begin
              if (mem_write) begin
                dirty_mem[a_idx][lk_way] <= 1'b1;
              end
            end else begin
              lat_tag    <= a_tag;
              lat_vtag   <= tag_mem[a_idx][vic_way];
              lat_idx    <= a_idx;
              lat_way    <= vic_way;
              lat_by_ptr <= ~vic_found;
              beat       <= '0;
              state      <= vic_dirty ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat  <= '0;
              state <= REFILL;
            end else begin
              beat <= beat + OFF'(1);
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (last_beat) begin
              valid_mem[lat_idx][lat_way] <= 1'b1;
              dirty_mem[lat_idx][lat_way] <= 1'b0;
              tag_mem[lat_idx][lat_way]   <= lat_tag;
              // Only a pointer-chosen victim advances the pointer; filling an
              // invalid way leaves the rotation where it was.
              if (lat_by_ptr && (WAYS > 1)) begin
                rr_ptr[lat_idx] <= rr_ptr[lat_idx] + WB'(1);
              end
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat <= beat + OFF'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Bench for assoc_cache_controller with the default geometry (16 sets, 2 ways,
// 4-word blocks). A line-level model tracks valid/dirty/tag/pointer per set.
module tb_assoc_cache_controller;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int BW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in;
  logic        mem_read, mem_write, mem_ready;
  logic        stall, hit;
  logic [0:0]  cache_way;
  logic [3:0]  cache_index;
  logic [1:0]  cache_offset;
  logic        cache_we, cache_fill, mem_re, mem_we;
  logic [9:0]  mem_addr;

  always #5 clk = ~clk;

  assoc_cache_controller dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ready(mem_ready), .stall(stall), .hit(hit),
    .cache_way(cache_way), .cache_index(cache_index), .cache_offset(cache_offset),
    .cache_we(cache_we), .cache_fill(cache_fill), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr)
  );

  int vectors = 0;
  int miscompares = 0;

  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_ptr   [SETS];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 2;
    return 1'($urandom_range(0, 1));
  endfunction

  // Checks of a served (zero-stall) access in IDLE.
  task automatic hit_checks(input int idx, input int off, input int way, input bit wr);
    chk("hit_stall", stall, 0);
    chk("hit_flag", hit, 1);
    chk("hit_way", cache_way, way);
    chk("hit_index", cache_index, idx);
    chk("hit_offset", cache_offset, off);
    chk("hit_we", cache_we, wr);
    chk("hit_mem_re", mem_re, 0);
    chk("hit_mem_we", mem_we, 0);
    if (wr) chk("hit_fill", cache_fill, 0);
  endtask

  // One block transfer: write-back (wb=1) or refill (wb=0) of base..base+3.
  task automatic phase(input bit wb, input int base, input int idx, input int way,
                       input int mode, inout int stalls, inout int pulses);
    int b;
    int cyc;
    b = 0; cyc = 0;
    while (b < BW) begin
      mem_ready = ready_for(mode, cyc);
      #1;
      chk("xfer_stall", stall, 1);
      chk("xfer_mem_we", mem_we, wb);
      chk("xfer_mem_re", mem_re, !wb);
      chk("xfer_addr", mem_addr, base + b);
      chk("xfer_way", cache_way, way);
      chk("xfer_index", cache_index, idx);
      chk("xfer_offset", cache_offset, b);
      chk("xfer_cache_we", cache_we, !wb && mem_ready);
      if (!wb) chk("xfer_fill", cache_fill, 1);
      if (!wb && cache_we === 1'b1) pulses++;
      stalls++;
      if (mem_ready) b++;
      cyc++;
      tick();
      if (cyc > 200) begin
        chk("xfer_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic do_access(input logic [31:0] a, input bit wr, input bit both, input int mode,
                           output int way_o, output int stalls_o, output int pulses_o,
                           output bit was_hit);
    int idx, tg, off, hw, vic, exp_stalls;
    bit byptr, dirty_vic;
    idx = (a / 4) % 16; tg = (a / 64) % 16; off = a % 4;
    hw = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    addr_in = a; mem_write = wr; mem_read = !wr || both;
    mem_ready = 1'($urandom_range(0, 1));
    stalls_o = 0; pulses_o = 0;
    #1;
    if (hw >= 0) begin
      was_hit = 1; way_o = hw;
      hit_checks(idx, off, hw, wr);
      if (wr) m_dirty[idx][hw] = 1;
      tick();
    end else begin
      was_hit = 0;
      vic = -1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[idx][w]) vic = w;
      byptr = (vic < 0);
      if (byptr) vic = m_ptr[idx];
      way_o = vic;
      dirty_vic = m_valid[idx][vic] && m_dirty[idx][vic];
      chk("miss_stall", stall, 1);
      chk("miss_hit", hit, 0);
      chk("miss_mem_re", mem_re, 0);
      chk("miss_mem_we", mem_we, 0);
      stalls_o = 1;
      tick();
      if (dirty_vic)
        phase(1, m_tag[idx][vic] * 64 + idx * 4, idx, vic, mode, stalls_o, pulses_o);
      phase(0, tg * 64 + idx * 4, idx, vic, mode, stalls_o, pulses_o);
      chk("refill_pulses", pulses_o, BW);
      m_valid[idx][vic] = 1; m_dirty[idx][vic] = 0; m_tag[idx][vic] = tg;
      if (byptr) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
      if (mode == 0) begin
        exp_stalls = 1 + (dirty_vic ? BW : 0) + BW;
        chk("stall_cycles", stalls_o, exp_stalls);
      end
      // Replay of the held request.
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      hit_checks(idx, off, vic, wr);
      if (wr) m_dirty[idx][vic] = 1;
      tick();
    end
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int way, st, pu;
    bit h;
    int idx, tg, off, mode, op;
    logic [31:0] a;

    reset = 1; addr_in = 0; mem_read = 0; mem_write = 0; mem_ready = 0;
    model_reset();
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_cache_we", cache_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    reset = 0;
    tick();

    // Cold read miss, clean refill into way 0.
    do_access(32'h040, 0, 0, 0, way, st, pu, h);
    chk("d1_hit", h, 0); chk("d1_way", way, 0); chk("d1_stalls", st, 5); chk("d1_we", pu, 4);
    // Second block of set 0 lands in way 1; then both hit.
    do_access(32'h080, 0, 0, 0, way, st, pu, h);
    chk("d2_way", way, 1); chk("d2_stalls", st, 5);
    do_access(32'h042, 0, 0, 0, way, st, pu, h);
    chk("d3_hit", h, 1); chk("d3_way", way, 0);
    do_access(32'h083, 0, 0, 0, way, st, pu, h);
    chk("d4_hit", h, 1); chk("d4_way", way, 1);
    // Write hit dirties way 0; dirty eviction via pointer 0.
    do_access(32'h041, 1, 0, 0, way, st, pu, h);
    chk("d5_hit", h, 1); chk("d5_stalls", st, 0);
    do_access(32'h0C0, 0, 0, 0, way, st, pu, h);
    chk("d6_way", way, 0); chk("d6_stalls", st, 9);
    // Pointer now 1: next set-0 miss replaces way 1, memory ready 1-of-3.
    do_access(32'h200, 0, 0, 1, way, st, pu, h);
    chk("d7_way", way, 1); chk("d7_we", pu, 4);
    // Write miss on a clean victim, then that line is evicted dirty.
    do_access(32'h105, 1, 0, 0, way, st, pu, h);
    chk("d8_way", way, 0); chk("d8_stalls", st, 5);
    do_access(32'h145, 0, 0, 0, way, st, pu, h);
    chk("d9_way", way, 1);
    do_access(32'h185, 0, 0, 0, way, st, pu, h);
    chk("d10_way", way, 0); chk("d10_stalls", st, 9);

    // Reset during refill beat 2 aborts the transfer and invalidates all lines.
    addr_in = 32'h300; mem_read = 1; mem_write = 0; mem_ready = 1;
    #1;
    chk("ab_miss", stall, 1);
    tick();
    for (int b = 0; b < 2; b++) begin
      chk("ab_addr", mem_addr, 32'h300 + b);
      tick();
    end
    reset = 1; mem_ready = 0;
    #1;
    chk("ab_re_before", mem_re, 1);
    chk("ab_addr2", mem_addr, 32'h302);
    tick();
    reset = 0; mem_read = 0;
    #1;
    chk("ab_re_after", mem_re, 0);
    chk("ab_we_after", mem_we, 0);
    chk("ab_stall_after", stall, 0);
    model_reset();
    tick();
    do_access(32'h300, 0, 0, 0, way, st, pu, h);
    chk("ab_remiss", h, 0); chk("ab_stalls", st, 5); chk("ab_we", pu, 4);
    do_access(32'h042, 0, 0, 0, way, st, pu, h);
    chk("ab_lost_line", h, 0);

    // Randomized traffic over a few sets with many tags to force conflicts.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        mem_read = 0; mem_write = 0; mem_ready = 1'($urandom_range(0, 1));
        addr_in = $urandom;
        #1;
        chk("idle_stall", stall, 0);
        chk("idle_mem_re", mem_re, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_cache_we", cache_we, 0);
        tick();
      end else begin
        idx = $urandom_range(0, 2); tg = $urandom_range(0, 7); off = $urandom_range(0, 3);
        mode = $urandom_range(0, 2);
        a = ($urandom & 32'hFFFF_FC00) | 32'(tg * 64 + idx * 4 + off);
        do_access(a, (op >= 6), (op == 9), mode, way, st, pu, h);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
